// File: rtl/ex_alu_stage_if.sv
// Bundle between the ID stage, the hazard unit and the EX/MEM consumers of ex_alu_stage.
// master drives the ID fields and pipeline controls; slave is the execute stage itself.
interface ex_alu_stage_if #(
   parameter int DW = 32
);
   logic          id_valid;
   logic [5:0]    id_alufun;
   logic          id_signed;
   logic [DW-1:0] id_a;
   logic [DW-1:0] id_b;
   logic [4:0]    id_shamt;
   logic [4:0]    id_rd;
   logic          id_regwrite;
   logic          stall;
   logic          flush;
   logic          hold;

   logic          ex_branch_taken;
   logic          exmem_valid;
   logic [DW-1:0] exmem_result;
   logic [4:0]    exmem_rd;
   logic          exmem_regwrite;
   logic          exmem_ovf;

   modport master (
      output id_valid, id_alufun, id_signed, id_a, id_b, id_shamt, id_rd, id_regwrite,
      output stall, flush, hold,
      input  ex_branch_taken, exmem_valid, exmem_result, exmem_rd, exmem_regwrite, exmem_ovf
   );

   modport slave (
      input  id_valid, id_alufun, id_signed, id_a, id_b, id_shamt, id_rd, id_regwrite,
      input  stall, flush, hold,
      output ex_branch_taken, exmem_valid, exmem_result, exmem_rd, exmem_regwrite, exmem_ovf
   );
endinterface

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: ID/EX register, ALUFun evaluation, branch resolution and EX/MEM register.
// Optional signed add/sub overflow trap is enabled by defining EX_OVERFLOW_TRAP_EN.
module ex_alu_stage (
   input logic           clk,
   input logic           reset,
   ex_alu_stage_if.slave bus
);
   localparam int DW = 32;

   localparam logic [5:0] FUN_ADD  = 6'b000000;
   localparam logic [5:0] FUN_SUB  = 6'b000001;
   localparam logic [5:0] FUN_AND  = 6'b011000;
   localparam logic [5:0] FUN_OR   = 6'b011110;
   localparam logic [5:0] FUN_XOR  = 6'b010110;
   localparam logic [5:0] FUN_NOR  = 6'b010001;
   localparam logic [5:0] FUN_PASA = 6'b011010;
   localparam logic [5:0] FUN_SLL  = 6'b100000;
   localparam logic [5:0] FUN_SRL  = 6'b100001;
   localparam logic [5:0] FUN_SRA  = 6'b100011;
   localparam logic [5:0] FUN_SLT  = 6'b110101;
   localparam logic [5:0] FUN_BEQ  = 6'b110011;
   localparam logic [5:0] FUN_BNE  = 6'b110001;
   localparam logic [5:0] FUN_BLEZ = 6'b111101;
   localparam logic [5:0] FUN_BLTZ = 6'b111011;
   localparam logic [5:0] FUN_BGTZ = 6'b111111;

   logic          idex_valid_q,    idex_valid_d;
   logic [5:0]    idex_alufun_q,   idex_alufun_d;
   logic          idex_signed_q,   idex_signed_d;
   logic [DW-1:0] idex_a_q,        idex_a_d;
   logic [DW-1:0] idex_b_q,        idex_b_d;
   logic [4:0]    idex_shamt_q,    idex_shamt_d;
   logic [4:0]    idex_rd_q,       idex_rd_d;
   logic          idex_regwrite_q, idex_regwrite_d;

   logic          exmem_valid_q,    exmem_valid_d;
   logic [DW-1:0] exmem_result_q,   exmem_result_d;
   logic [4:0]    exmem_rd_q,       exmem_rd_d;
   logic          exmem_regwrite_q, exmem_regwrite_d;
   logic          exmem_ovf_q,      exmem_ovf_d;

   logic [DW-1:0] alu_result;
   logic [DW-1:0] add_sum;
   logic [DW-1:0] sub_diff;
   logic          cond;
   logic          is_branch;
   logic          trap;

   // hold outranks flush, which outranks stall; a flushed slot is zeroed so it computes nothing
   always_comb begin
      idex_valid_d    = idex_valid_q;
      idex_alufun_d   = idex_alufun_q;
      idex_signed_d   = idex_signed_q;
      idex_a_d        = idex_a_q;
      idex_b_d        = idex_b_q;
      idex_shamt_d    = idex_shamt_q;
      idex_rd_d       = idex_rd_q;
      idex_regwrite_d = idex_regwrite_q;
      if (!bus.hold) begin
         if (bus.flush) begin
            idex_valid_d    = 1'b0;
            idex_alufun_d   = '0;
            idex_signed_d   = 1'b0;
            idex_a_d        = '0;
            idex_b_d        = '0;
            idex_shamt_d    = '0;
            idex_rd_d       = '0;
            idex_regwrite_d = 1'b0;
         end else if (!bus.stall) begin
            idex_valid_d    = bus.id_valid;
            idex_alufun_d   = bus.id_alufun;
            idex_signed_d   = bus.id_signed;
            idex_a_d        = bus.id_a;
            idex_b_d        = bus.id_b;
            idex_shamt_d    = bus.id_shamt;
            idex_rd_d       = bus.id_rd;
            idex_regwrite_d = bus.id_regwrite;
         end
      end
   end

   always_comb begin
      add_sum    = idex_a_q + idex_b_q;
      sub_diff   = idex_a_q - idex_b_q;
      alu_result = '0;
      cond       = 1'b0;
      is_branch  = 1'b0;
      case (idex_alufun_q)
         FUN_ADD:  alu_result = add_sum;
         FUN_SUB:  alu_result = sub_diff;
         FUN_AND:  alu_result = idex_a_q & idex_b_q;
         FUN_OR:   alu_result = idex_a_q | idex_b_q;
         FUN_XOR:  alu_result = idex_a_q ^ idex_b_q;
         FUN_NOR:  alu_result = ~(idex_a_q | idex_b_q);
         FUN_PASA: alu_result = idex_a_q;
         FUN_SLL:  alu_result = idex_b_q << idex_shamt_q;
         FUN_SRL:  alu_result = idex_b_q >> idex_shamt_q;
         FUN_SRA:  alu_result = $unsigned($signed(idex_b_q) >>> idex_shamt_q);
         FUN_SLT:  cond = ($signed(idex_a_q) < $signed(idex_b_q));
         FUN_BEQ: begin
            is_branch = 1'b1;
            cond      = (idex_a_q == idex_b_q);
         end
         FUN_BNE: begin
            is_branch = 1'b1;
            cond      = (idex_a_q != idex_b_q);
         end
         FUN_BLEZ: begin
            is_branch = 1'b1;
            cond      = idex_a_q[DW-1] || (idex_a_q == '0);
         end
         FUN_BLTZ: begin
            is_branch = 1'b1;
            cond      = idex_a_q[DW-1];
         end
         FUN_BGTZ: begin
            is_branch = 1'b1;
            cond      = !idex_a_q[DW-1] && (idex_a_q != '0);
         end
         default: begin
            alu_result = '0;
            cond       = 1'b0;
         end
      endcase
      if (is_branch || (idex_alufun_q == FUN_SLT)) begin
         alu_result = {{(DW-1){1'b0}}, cond};
      end
   end

`ifdef EX_OVERFLOW_TRAP_EN
   logic add_ovf;
   logic sub_ovf;

   // overflow when the result sign disagrees with operands that share (add) or differ in (sub) sign
   always_comb begin
      add_ovf = (idex_a_q[DW-1] == idex_b_q[DW-1]) && (add_sum[DW-1] != idex_a_q[DW-1]);
      sub_ovf = (idex_a_q[DW-1] != idex_b_q[DW-1]) && (sub_diff[DW-1] != idex_a_q[DW-1]);
      trap    = idex_valid_q && idex_signed_q &&
                (((idex_alufun_q == FUN_ADD) && add_ovf) ||
                 ((idex_alufun_q == FUN_SUB) && sub_ovf));
   end
`else
   logic unused_signed;

   assign unused_signed = idex_signed_q;
   assign trap          = 1'b0;
`endif

   // stall only bubbles EX/MEM; flush lets the branch already in EX complete
   always_comb begin
      exmem_valid_d    = exmem_valid_q;
      exmem_result_d   = exmem_result_q;
      exmem_rd_d       = exmem_rd_q;
      exmem_regwrite_d = exmem_regwrite_q;
      exmem_ovf_d      = exmem_ovf_q;
      if (!bus.hold) begin
         if (bus.stall) begin
            exmem_valid_d    = 1'b0;
            exmem_result_d   = '0;
            exmem_rd_d       = '0;
            exmem_regwrite_d = 1'b0;
            exmem_ovf_d      = 1'b0;
         end else begin
            exmem_valid_d    = idex_valid_q;
            exmem_result_d   = alu_result;
            exmem_rd_d       = idex_rd_q;
            exmem_regwrite_d = idex_regwrite_q && idex_valid_q && !trap;
            exmem_ovf_d      = trap;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_valid_q     <= 1'b0;
         idex_alufun_q    <= '0;
         idex_signed_q    <= 1'b0;
         idex_a_q         <= '0;
         idex_b_q         <= '0;
         idex_shamt_q     <= '0;
         idex_rd_q        <= '0;
         idex_regwrite_q  <= 1'b0;
         exmem_valid_q    <= 1'b0;
         exmem_result_q   <= '0;
         exmem_rd_q       <= '0;
         exmem_regwrite_q <= 1'b0;
         exmem_ovf_q      <= 1'b0;
      end else begin
         idex_valid_q     <= idex_valid_d;
         idex_alufun_q    <= idex_alufun_d;
         idex_signed_q    <= idex_signed_d;
         idex_a_q         <= idex_a_d;
         idex_b_q         <= idex_b_d;
         idex_shamt_q     <= idex_shamt_d;
         idex_rd_q        <= idex_rd_d;
         idex_regwrite_q  <= idex_regwrite_d;
         exmem_valid_q    <= exmem_valid_d;
         exmem_result_q   <= exmem_result_d;
         exmem_rd_q       <= exmem_rd_d;
         exmem_regwrite_q <= exmem_regwrite_d;
         exmem_ovf_q      <= exmem_ovf_d;
      end
   end

   assign bus.ex_branch_taken = idex_valid_q && is_branch && cond;
   assign bus.exmem_valid     = exmem_valid_q;
   assign bus.exmem_result    = exmem_result_q;
   assign bus.exmem_rd        = exmem_rd_q;
   assign bus.exmem_regwrite  = exmem_regwrite_q;
   assign bus.exmem_ovf       = exmem_ovf_q;
endmodule
